// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, opcode/funct constants, ALU-op encoding and decode record
package mips_pkg;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_NOR = 3'd5;
  localparam logic [2:0] ALU_SLL = 3'd6;
  localparam logic [2:0] ALU_SRL = 3'd7;
  typedef struct packed {
    logic [2:0] aluop;
    logic       imm_sel;
    logic       sign_ext;
    logic       shift;
    logic       rt_src;
    logic       r_type;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       legal;
  } dec_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-to-EX instruction handshake and operand bus
interface id_ex_stage_if #(
  parameter int DW = mips_pkg::DW,
  parameter int RW = mips_pkg::RW
);
  logic          id_valid;
  logic          id_ready;
  logic [5:0]    id_opcode;
  logic [5:0]    id_funct;
  logic [4:0]    id_shamt;
  logic [15:0]   id_imm16;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  modport master (
    output id_valid, id_opcode, id_funct, id_shamt, id_imm16,
           id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
    input  id_ready
  );
  modport slave (
    input  id_valid, id_opcode, id_funct, id_shamt, id_imm16,
           id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
    output id_ready
  );
endinterface

// File: rtl/alu_op_decode.sv
// alu_op_decode: opcode/funct to ALU op, operand selects, extension mode and control bits
module alu_op_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);
  // unsupported encodings fall through to all-zero, i.e. a bubble with no side effects
  always_comb begin
    dec = '0;
    if (opcode == OP_RTYPE) begin
      dec.r_type    = 1'b1;
      dec.rt_src    = 1'b1;
      dec.reg_write = 1'b1;
      dec.legal     = 1'b1;
      case (funct)
        FN_ADD:  dec.aluop = ALU_ADD;
        FN_SUB:  dec.aluop = ALU_SUB;
        FN_AND:  dec.aluop = ALU_AND;
        FN_OR:   dec.aluop = ALU_OR;
        FN_SLT:  dec.aluop = ALU_SLT;
        FN_NOR:  dec.aluop = ALU_NOR;
        FN_SLL:  begin dec.aluop = ALU_SLL; dec.shift = 1'b1; end
        FN_SRL:  begin dec.aluop = ALU_SRL; dec.shift = 1'b1; end
        default: dec = '0;
      endcase
    end else begin
      case (opcode)
        OP_ADDI: begin dec.aluop = ALU_ADD; dec.imm_sel = 1'b1; dec.sign_ext = 1'b1; dec.reg_write = 1'b1; dec.legal = 1'b1; end
        OP_LW:   begin dec.aluop = ALU_ADD; dec.imm_sel = 1'b1; dec.sign_ext = 1'b1; dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.legal = 1'b1; end
        OP_SW:   begin dec.aluop = ALU_ADD; dec.imm_sel = 1'b1; dec.sign_ext = 1'b1; dec.rt_src = 1'b1; dec.mem_write = 1'b1; dec.legal = 1'b1; end
        OP_BEQ:  begin dec.aluop = ALU_SUB; dec.rt_src = 1'b1; dec.legal = 1'b1; end
        OP_ANDI: begin dec.aluop = ALU_AND; dec.imm_sel = 1'b1; dec.reg_write = 1'b1; dec.legal = 1'b1; end
        OP_ORI:  begin dec.aluop = ALU_OR; dec.imm_sel = 1'b1; dec.reg_write = 1'b1; dec.legal = 1'b1; end
        OP_SLTI: begin dec.aluop = ALU_SLT; dec.imm_sel = 1'b1; dec.sign_ext = 1'b1; dec.reg_write = 1'b1; dec.legal = 1'b1; end
        default: dec = '0;
      endcase
    end
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with decode, immediate extension, forwarding and load-use stall (ID_EX_FORWARD_EN enables MEM/WB forwarding)
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = mips_pkg::DW,
  parameter int RW = mips_pkg::RW
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  id,
  input  logic          ex_stall,
  input  logic          flush,
  input  logic          mem_wr_en,
  input  logic [RW-1:0] mem_wr_reg,
  input  logic [DW-1:0] mem_wr_data,
  input  logic          wb_wr_en,
  input  logic [RW-1:0] wb_wr_reg,
  input  logic [DW-1:0] wb_wr_data,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [2:0]    aluop,
  output logic [4:0]    shamt,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic [RW-1:0] ex_dest_reg,
  output logic [DW-1:0] ex_store_data
);
  dec_t          dec;
  logic [RW-1:0] rs_idx, rt_idx;
  logic [DW-1:0] rs_val, rt_val, imm_ext, fwd_rs, fwd_rt;
  logic          in1_rt, in2_imm, load_use, hazard;

  function automatic logic hit(input logic [RW-1:0] a, input logic [RW-1:0] b);
    return a != '0 && a == b;
  endfunction

  function automatic logic src_hit(input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic rt_src, input logic [RW-1:0] dst);
    return hit(rs, dst) || (rt_src && hit(rt, dst));
  endfunction

  alu_op_decode u_dec (.opcode(id.id_opcode), .funct(id.id_funct), .dec(dec));

  assign load_use = ex_valid && ex_mem_read && src_hit(id.id_rs, id.id_rt, dec.rt_src, ex_dest_reg);

`ifdef ID_EX_FORWARD_EN
  assign fwd_rs = (mem_wr_en && hit(rs_idx, mem_wr_reg)) ? mem_wr_data : (wb_wr_en && hit(rs_idx, wb_wr_reg)) ? wb_wr_data : rs_val;
  assign fwd_rt = (mem_wr_en && hit(rt_idx, mem_wr_reg)) ? mem_wr_data : (wb_wr_en && hit(rt_idx, wb_wr_reg)) ? wb_wr_data : rt_val;
  assign hazard = load_use;
`else
  logic unused_fwd;
  assign unused_fwd = ^{mem_wr_data, wb_wr_data, rs_idx, rt_idx};
  assign fwd_rs = rs_val;
  assign fwd_rt = rt_val;
  // without forwarding any in-flight writer of a source register must drain first
  assign hazard = load_use
    || (ex_valid && ex_reg_write && src_hit(id.id_rs, id.id_rt, dec.rt_src, ex_dest_reg))
    || (mem_wr_en && src_hit(id.id_rs, id.id_rt, dec.rt_src, mem_wr_reg))
    || (wb_wr_en && src_hit(id.id_rs, id.id_rt, dec.rt_src, wb_wr_reg));
`endif

  assign id.id_ready     = !ex_stall && !hazard;
  assign alu_in1         = in1_rt ? fwd_rt : fwd_rs;
  assign alu_in2         = in2_imm ? imm_ext : fwd_rt;
  assign ex_store_data   = fwd_rt;

  // flush > stall (refresh held operands) > bubble on hazard/no input > load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, in1_rt, in2_imm} <= '0;
      {ex_dest_reg, rs_idx, rt_idx, aluop, shamt} <= '0;
      {rs_val, rt_val, imm_ext} <= '0;
    end else if (flush) begin
      {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} <= '0;
    end else if (ex_stall) begin
      rs_val <= fwd_rs;
      rt_val <= fwd_rt;
    end else if (id.id_valid && !hazard) begin
      ex_valid     <= dec.legal;
      ex_reg_write <= dec.reg_write;
      ex_mem_read  <= dec.mem_read;
      ex_mem_write <= dec.mem_write;
      ex_dest_reg  <= dec.r_type ? id.id_rd : id.id_rt;
      aluop        <= dec.aluop;
      shamt        <= id.id_shamt;
      in1_rt       <= dec.shift;
      in2_imm      <= dec.imm_sel;
      rs_idx       <= id.id_rs;
      rt_idx       <= id.id_rt;
      rs_val       <= id.id_rs_data;
      rt_val       <= id.id_rt_data;
      imm_ext      <= {{(DW-16){dec.sign_ext & id.id_imm16[15]}}, id.id_imm16};
    end else begin
      {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} <= '0;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven decode checks plus forwarding, load-use, stall, flush and reset sequences
module tb_id_ex_stage;
`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, ex_stall = 1'b0, flush = 1'b0;
  logic mem_wr_en = 1'b0, wb_wr_en = 1'b0;
  logic [4:0] mem_wr_reg = '0, wb_wr_reg = '0;
  logic [31:0] mem_wr_data = '0, wb_wr_data = '0;
  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic [2:0] aluop;
  logic [4:0] shamt, ex_dest_reg;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  int checks = 0, errors = 0;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id(bus), .ex_stall(ex_stall), .flush(flush),
    .mem_wr_en(mem_wr_en), .mem_wr_reg(mem_wr_reg), .mem_wr_data(mem_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg), .wb_wr_data(wb_wr_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .aluop(aluop), .shamt(shamt),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_dest_reg(ex_dest_reg), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op, fn; logic [4:0] sh; logic [15:0] imm;
    logic [4:0] rs, rt, rd; logic [31:0] rs_d, rt_d;
    logic [2:0] aluop; logic [31:0] in1, in2; logic [4:0] dest;
    logic v, rw, mr, mw;
  } vec_t;

  vec_t vecs[17];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic present(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [31:0] rsd, input logic [31:0] rtd);
    bus.id_opcode = op; bus.id_funct = fn; bus.id_shamt = '0; bus.id_imm16 = imm;
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_valid = 1'b1;
  endtask

  task automatic apply(input int i, input vec_t v);
    vec_t e;
    @(negedge clk);
    present(v.op, v.fn, v.rs, v.rt, v.rd, v.imm, v.rs_d, v.rt_d);
    bus.id_shamt = v.sh;
    #1 chk($sformatf("v%0d_ready", i), bus.id_ready, 1);
    exp_q.push_back(v);
    @(posedge clk);
    #1 bus.id_valid = 1'b0;
    e = exp_q.pop_front();
    chk($sformatf("v%0d_valid", i), ex_valid, e.v);
    chk($sformatf("v%0d_rw", i), ex_reg_write, e.rw);
    chk($sformatf("v%0d_mr", i), ex_mem_read, e.mr);
    chk($sformatf("v%0d_mw", i), ex_mem_write, e.mw);
    if (e.v) begin
      chk($sformatf("v%0d_aluop", i), aluop, e.aluop);
      chk($sformatf("v%0d_in1", i), alu_in1, e.in1);
      chk($sformatf("v%0d_in2", i), alu_in2, e.in2);
      chk($sformatf("v%0d_dest", i), ex_dest_reg, e.dest);
      chk($sformatf("v%0d_shamt", i), shamt, e.sh);
      chk($sformatf("v%0d_store", i), ex_store_data, e.rt_d);
    end
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.id_valid = 1'b0; bus.id_opcode = '0; bus.id_funct = '0; bus.id_shamt = '0; bus.id_imm16 = '0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0; bus.id_rs_data = '0; bus.id_rt_data = '0;
    //           op     fn     sh    imm       rs    rt    rd     rs_d          rt_d          aluop in1           in2           dest  v     rw    mr    mw
    vecs[0]  = '{6'h00, 6'h20, 5'd0, 16'h0000, 5'd1, 5'd2, 5'd3,  32'd5,        32'd7,        3'd0, 32'd5,        32'd7,        5'd3,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{6'h0C, 6'h00, 5'd0, 16'hFFFF, 5'd1, 5'd5, 5'd0,  32'h12345678, 32'h9,        3'd2, 32'h12345678, 32'h0000FFFF, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{6'h08, 6'h00, 5'd0, 16'hFFFF, 5'd1, 5'd6, 5'd0,  32'd3,        32'd0,        3'd0, 32'd3,        32'hFFFFFFFF, 5'd6,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{6'h00, 6'h22, 5'd0, 16'h0000, 5'd1, 5'd2, 5'd6,  32'd20,       32'd3,        3'd1, 32'd20,       32'd3,        5'd6,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{6'h00, 6'h24, 5'd0, 16'h0000, 5'd3, 5'd4, 5'd7,  32'hF0F0,     32'h0FF0,     3'd2, 32'hF0F0,     32'h0FF0,     5'd7,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{6'h00, 6'h25, 5'd0, 16'h0000, 5'd3, 5'd4, 5'd8,  32'hF0F0,     32'h0FF0,     3'd3, 32'hF0F0,     32'h0FF0,     5'd8,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{6'h00, 6'h2A, 5'd0, 16'h0000, 5'd3, 5'd4, 5'd9,  32'h1,        32'h2,        3'd4, 32'h1,        32'h2,        5'd9,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{6'h00, 6'h27, 5'd0, 16'h0000, 5'd3, 5'd4, 5'd10, 32'h1,        32'h2,        3'd5, 32'h1,        32'h2,        5'd10, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{6'h00, 6'h00, 5'd4, 16'h0000, 5'd0, 5'd2, 5'd11, 32'hDEAD,     32'h11,       3'd6, 32'h11,       32'h11,       5'd11, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{6'h00, 6'h02, 5'd31,16'h0000, 5'd0, 5'd2, 5'd12, 32'hBEEF,     32'h80000000, 3'd7, 32'h80000000, 32'h80000000, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{6'h23, 6'h00, 5'd0, 16'h0008, 5'd1, 5'd9, 5'd0,  32'h1000,     32'h77,       3'd0, 32'h1000,     32'h8,        5'd9,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{6'h2B, 6'h00, 5'd0, 16'hFFFC, 5'd1, 5'd7, 5'd0,  32'h2000,     32'hABCD,     3'd0, 32'h2000,     32'hFFFFFFFC, 5'd7,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{6'h04, 6'h00, 5'd0, 16'h0010, 5'd1, 5'd2, 5'd0,  32'd5,        32'd6,        3'd1, 32'd5,        32'd6,        5'd2,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{6'h0D, 6'h00, 5'd0, 16'h8001, 5'd1, 5'd3, 5'd0,  32'h10000000, 32'd0,        3'd3, 32'h10000000, 32'h00008001, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{6'h0A, 6'h00, 5'd0, 16'h8000, 5'd1, 5'd3, 5'd0,  32'd7,        32'd0,        3'd4, 32'd7,        32'hFFFF8000, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{6'h3F, 6'h00, 5'd0, 16'h1234, 5'd1, 5'd2, 5'd3,  32'd1,        32'd2,        3'd0, 32'd0,        32'd0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{6'h00, 6'h21, 5'd0, 16'h0000, 5'd1, 5'd2, 5'd3,  32'd1,        32'd2,        3'd0, 32'd0,        32'd0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", ex_valid, 0);
    chk("rst_aluop", aluop, 0);
    chk("rst_in1", alu_in1, 0);
    chk("rst_in2", alu_in2, 0);
    chk("rst_dest", ex_dest_reg, 0);
    chk("rst_ready", bus.id_ready, 1);
    rst = 1'b0;

    foreach (vecs[i]) apply(i, vecs[i]);

    // MEM beats WB on the same register; WB alone also forwards
    @(negedge clk);
    present(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 32'd100, 32'd7);
    @(posedge clk);
    #1 bus.id_valid = 1'b0;
    mem_wr_en = 1'b1; mem_wr_reg = 5'd1; mem_wr_data = 32'd9;
    wb_wr_en = 1'b1; wb_wr_reg = 5'd1; wb_wr_data = 32'd4;
    #1 chk("fwd_mem_over_wb", alu_in1, FWD ? 32'd9 : 32'd100);
    mem_wr_en = 1'b0;
    #1 chk("fwd_wb", alu_in1, FWD ? 32'd4 : 32'd100);
    wb_wr_en = 1'b0;
    @(posedge clk);
    // register 0 is never forwarded
    @(negedge clk);
    present(6'h00, 6'h20, 5'd0, 5'd2, 5'd3, 16'h0, 32'd55, 32'd7);
    @(posedge clk);
    #1 bus.id_valid = 1'b0;
    mem_wr_en = 1'b1; mem_wr_reg = 5'd0; mem_wr_data = 32'd9;
    wb_wr_en = 1'b1; wb_wr_reg = 5'd0; wb_wr_data = 32'd4;
    #1 chk("fwd_r0", alu_in1, 32'd55);
    mem_wr_en = 1'b0; wb_wr_en = 1'b0;
    @(posedge clk);

    // load-use: lw r2 then sub r4,r2,r1 -> one bubble
    @(negedge clk);
    present(6'h23, 6'h00, 5'd1, 5'd2, 5'd0, 16'h0, 32'h100, 32'h0);
    @(posedge clk);
    @(negedge clk);
    present(6'h00, 6'h22, 5'd2, 5'd1, 5'd4, 16'h0, 32'd50, 32'd8);
    #1 chk("lu_ready0", bus.id_ready, 0);
    @(posedge clk);
    #1 chk("lu_bubble", ex_valid, 0);
    @(negedge clk);
    chk("lu_ready1", bus.id_ready, 1);
    @(posedge clk);
    #1 bus.id_valid = 1'b0;
    chk("lu_valid", ex_valid, 1);
    chk("lu_aluop", aluop, 1);
    chk("lu_dest", ex_dest_reg, 4);
    chk("lu_in1", alu_in1, 32'd50);
    // load-use only counts rt when rt is read
    @(negedge clk);
    present(6'h23, 6'h00, 5'd1, 5'd2, 5'd0, 16'h0, 32'h100, 32'h0);
    @(posedge clk);
    @(negedge clk);
    present(6'h0D, 6'h00, 5'd1, 5'd2, 5'd0, 16'h1, 32'd1, 32'd0);
    #1 chk("lu_rt_dest_ready", bus.id_ready, 1);
    present(6'h2B, 6'h00, 5'd1, 5'd2, 5'd0, 16'h1, 32'd1, 32'd0);
    #1 chk("lu_sw_rt_ready", bus.id_ready, 0);
    // reset mid-hazard clears the stage at once
    rst = 1'b1;
    #1 chk("rst_hz_valid", ex_valid, 0);
    chk("rst_hz_mr", ex_mem_read, 0);
    chk("rst_hz_ready", bus.id_ready, 1);
    bus.id_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // three-cycle stall with a WB retire on its first cycle
    @(negedge clk);
    present(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 32'd100, 32'd7);
    @(posedge clk);
    @(negedge clk);
    ex_stall = 1'b1;
    wb_wr_en = 1'b1; wb_wr_reg = 5'd1; wb_wr_data = 32'd11;
    present(6'h00, 6'h22, 5'd5, 5'd6, 5'd8, 16'h0, 32'd1, 32'd2);
    #1 chk("stall_ready", bus.id_ready, 0);
    @(posedge clk);
    #1 wb_wr_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ex_stall = 1'b0; bus.id_valid = 1'b0;
    #1 chk("stall_in1", alu_in1, FWD ? 32'd11 : 32'd100);
    chk("stall_valid", ex_valid, 1);
    chk("stall_aluop", aluop, 0);
    chk("stall_dest", ex_dest_reg, 3);
    // flush beats stall
    flush = 1'b1; ex_stall = 1'b1;
    @(posedge clk);
    #1 chk("flush_valid", ex_valid, 0);
    chk("flush_rw", ex_reg_write, 0);
    flush = 1'b0; ex_stall = 1'b0;

    // reset pulse mid-stall
    @(negedge clk);
    present(6'h23, 6'h00, 5'd1, 5'd9, 5'd0, 16'h0004, 32'd100, 32'd7);
    @(posedge clk);
    #1 bus.id_valid = 1'b0;
    ex_stall = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_st_valid", ex_valid, 0);
    chk("rst_st_in1", alu_in1, 0);
    chk("rst_st_in2", alu_in2, 0);
    chk("rst_st_dest", ex_dest_reg, 0);
    chk("rst_st_store", ex_store_data, 0);
    chk("rst_st_mr", ex_mem_read, 0);
    chk("rst_st_rw", ex_reg_write, 0);
    @(negedge clk);
    rst = 1'b0; ex_stall = 1'b0;
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage that sits directly upstream of the MIPS ALU and drives its `in1`, `in2`, `aluop` and `shamt` inputs. It does the following:
- registers the decoded instruction;
- maps opcode/funct to the 3-bit ALU operation;
- sign- or zero-extends immediates;
- forwards results from the MEM and WB stages;
- detects load-use hazards and inserts a bubble.

It also carries the control bits that later stages need: register write, memory read/write, destination register and store data.

## Interface
Parameters:
- `DW`, 32, datapath width.
- `RW`, 5, register index width.

Ports:
- `clk` in 1: the only clock; all state updates on the rising edge.
- `rst` in 1: reset, **asynchronous, active-high**.
- `id_valid` in 1: decode presents an instruction.
- `id_ready` out 1: the stage accepts the instruction this cycle.
- `id_opcode` in 6, `id_funct` in 6, `id_shamt` in 5, `id_imm16` in 16: instruction fields.
- `id_rs`, `id_rt`, `id_rd` in RW: register indices.
- `id_rs_data`, `id_rt_data` in DW: register-file read data.
- `ex_stall` in 1: downstream cannot advance; hold all state.
- `flush` in 1: kill the held instruction (branch taken).
- `mem_wr_en` in 1, `mem_wr_reg` in RW, `mem_wr_data` in DW: MEM-stage pending write.
- `wb_wr_en` in 1, `wb_wr_reg` in RW, `wb_wr_data` in DW: WB-stage write.
- `alu_in1`, `alu_in2` out DW: ALU operands, forwarded.
- `aluop` out 3: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 nor, 6 sll, 7 srl.
- `shamt` out 5: shift amount.
- `ex_valid` out 1: the held instruction is real (not a bubble).
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1: control bits.
- `ex_dest_reg` out RW: `rd` for R-type, `rt` for I-type.
- `ex_store_data` out DW: forwarded `rt` value for sw.

## Operation
Decode mapping:
- R-type (opcode 0): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x27 nor, 0x00 sll, 0x02 srl.
- I-type: addi 0x08 / lw 0x23 / sw 0x2B → add; beq 0x04 → sub; andi 0x0C → and; ori 0x0D → or; slti 0x0A → slt.
- Any other encoding is accepted as a bubble: `ex_valid` = 0.

Immediates:
- Sign-extended for addi, lw, sw, slti.
- Zero-extended for andi, ori.

Operand selection:
- `alu_in1` = rs, except for sll/srl, where it is rt.
- `alu_in2` = rt for R-type and beq; the extended immediate otherwise.

Control bits:
- `ex_reg_write` = 1 for R-type, addi, andi, ori, slti, lw.
- `ex_mem_read` = 1 for lw only.
- `ex_mem_write` = 1 for sw only.
- beq writes no register.

Forwarding is a combinational mux on the registered rs/rt values:
- A MEM match (`mem_wr_en`, `mem_wr_reg` == index, index ≠ 0) takes priority over a WB match; otherwise the registered value is used.
- Register 0 is never forwarded.

Load-use hazard:
- Condition: `ex_valid`, `ex_mem_read`, `ex_dest_reg` ≠ 0, and `ex_dest_reg` equals `id_rs`, or equals `id_rt` when rt is a source.
- `id_ready` = !`ex_stall` && !hazard.

## Timing
- Reset: every registered output and internal register is 0, which gives `ex_valid` = 0 and `aluop` = 0. `id_ready` follows its combinational equation.
- Latency: an instruction accepted at edge N drives the ALU in cycle N+1.

Each rising edge, in priority order:
1. `flush` = 1: `ex_valid` ← 0 and control bits ← 0. Flush beats stall.
2. `ex_stall` = 1: hold the instruction. The held rs/rt values are overwritten with their forwarded values, so a WB write that retires during the stall is not lost.
3. Hazard active: insert a bubble (`ex_valid` ← 0). Decode retries the next cycle.
4. `id_valid` && `id_ready`: load the new instruction.
5. Otherwise: `ex_valid` ← 0.

Other rules:
- Reset mid-stall or mid-hazard discards everything immediately; no partial instruction survives.
- When `flush`, `ex_stall` and a hazard coincide, the result is flush.

## Configuration
Macro `ID_EX_FORWARD_EN`:
- Defined: operand forwarding as described above.
- Undefined:
  - The forwarding ports are ignored for data; operands come straight from the register file.
  - `id_ready` is also deasserted whenever a nonzero source of the incoming instruction matches a pending destination in EX (`ex_valid` && `ex_reg_write`), MEM (`mem_wr_en`) or WB (`wb_wr_en`).
  - Each such cycle inserts a bubble.

## Structure
- Shared package `mips_pkg` holds:
  - opcode and funct constants;
  - the 3-bit ALU-op encoding constants (0–7);
  - the widths `DW` and `RW`.
- One combinational sub-module, `alu_op_decode`:
  - inputs: opcode, funct;
  - outputs: `aluop`, immediate-select, sign/zero-extend, control bits, legal flag.

## Test plan
- After reset, `id_valid` = 1 with add r3,r1,r2 (r1 = 5, r2 = 7) → next cycle `aluop` = 0, `alu_in1` = 5, `alu_in2` = 7, `ex_dest_reg` = 3, `ex_valid` = 1.
- andi with imm 0xFFFF → `alu_in2` = 0x0000FFFF; addi with imm 0xFFFF → `alu_in2` = 0xFFFFFFFF.
- Same register, MEM data 9 and WB data 4 (MEM to r1 = 9, WB to r1 = 4), held rs = r1 → `alu_in1` = 9. The same case with the index set to r0 instead → `alu_in1` = stale register value.
- lw r2 in EX, then sub r4,r2,r1 presented → `id_ready` = 0 for one cycle and one bubble (`ex_valid` = 0), then sub is accepted.
- `ex_stall` held 3 cycles while WB writes r1 = 11 in the first of them → held `alu_in1` = 11 after the stall releases.
- `flush` and `ex_stall` asserted together → `ex_valid` = 0 next cycle; `rst` pulse mid-stall → all outputs 0 immediately.
